// File: rtl/uart_rx_param.sv
// 16x-oversampled UART receiver with programmable frame format, RX FIFO,
// watermark and sticky error flags.
module uart_rx_param #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AW         = $clog2(FIFO_DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          rx_en,
    input  logic [15:0]   div,
    input  logic [1:0]    data_bits,
    input  logic [1:0]    parity_mode,
    input  logic          nstop,
    input  logic [AW-1:0] watermark,
    input  logic          err_clr,
    input  logic          rxd,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic          rxwm,
    output logic          parity_err,
    output logic          frame_err,
    output logic          overrun
);

    localparam int unsigned LW        = AW + 1;
    localparam logic [AW:0] DEPTH_L   = LW'(FIFO_DEPTH);
    localparam logic [3:0]  SAMP_MID  = 4'd7;
    localparam logic [3:0]  SAMP_LAST = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t      state, state_next;
    logic        rx_meta, rxs;
    logic [15:0] tick_cnt, div_q;
    logic        tick;
    logic [3:0]  samp_cnt, samp_next;
    logic [2:0]  bit_cnt, bit_next;
    logic [7:0]  shift_q, shift_next;
    logic [1:0]  fmt_bits, fmt_bits_next;
    logic [1:0]  fmt_par, fmt_par_next;
    logic        fmt_nstop, fmt_nstop_next;
    logic        push_c, perr_set, ferr_set;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop, ovr_set;

    // Two-flop synchroniser for the asynchronous serial line
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    // Oversample tick; divisor is re-latched only at each wrap
    assign tick = (tick_cnt >= div_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt <= '0;
            div_q    <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            div_q    <= div;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next     = state;
        samp_next      = samp_cnt;
        bit_next       = bit_cnt;
        shift_next     = shift_q;
        fmt_bits_next  = fmt_bits;
        fmt_par_next   = fmt_par;
        fmt_nstop_next = fmt_nstop;
        push_c         = 1'b0;
        perr_set       = 1'b0;
        ferr_set       = 1'b0;
        if (!rx_en) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        samp_next  = '0;
                        shift_next = '0;
                        state_next = S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        samp_next = samp_cnt + 4'd1;
                        if (samp_cnt == SAMP_MID && rxs) begin
                            state_next = S_IDLE;
                        end else if (samp_cnt == SAMP_LAST) begin
                            state_next     = S_DATA;
                            bit_next       = '0;
                            fmt_bits_next  = data_bits;
                            fmt_par_next   = parity_mode;
                            fmt_nstop_next = nstop;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        samp_next = samp_cnt + 4'd1;
                        if (samp_cnt == SAMP_MID)
                            shift_next = shift_q | (8'(rxs) << bit_cnt);
                        if (samp_cnt == SAMP_LAST) begin
                            if (bit_cnt == 3'(fmt_bits) + 3'd4)
                                state_next = (fmt_par[0] ^ fmt_par[1]) ? S_PARITY : S_STOP1;
                            else
                                bit_next = bit_cnt + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        samp_next = samp_cnt + 4'd1;
                        // fmt_par[1] is the required XOR: 0 for even, 1 for odd
                        if (samp_cnt == SAMP_MID)
                            perr_set = ((^shift_q) ^ rxs) != fmt_par[1];
                        if (samp_cnt == SAMP_LAST)
                            state_next = S_STOP1;
                    end
                end
                S_STOP1: begin
                    if (tick) begin
                        samp_next = samp_cnt + 4'd1;
                        if (samp_cnt == SAMP_MID) begin
                            ferr_set = !rxs;
                            if (!fmt_nstop) begin
                                push_c     = 1'b1;
                                state_next = S_IDLE;
                            end
                        end else if (samp_cnt == SAMP_LAST) begin
                            state_next = S_STOP2;
                        end
                    end
                end
                S_STOP2: begin
                    if (tick) begin
                        samp_next = samp_cnt + 4'd1;
                        if (samp_cnt == SAMP_MID) begin
                            ferr_set   = !rxs;
                            push_c     = 1'b1;
                            state_next = S_IDLE;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            samp_cnt  <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            fmt_bits  <= '0;
            fmt_par   <= '0;
            fmt_nstop <= 1'b0;
        end else begin
            samp_cnt  <= samp_next;
            bit_cnt   <= bit_next;
            shift_q   <= shift_next;
            fmt_bits  <= fmt_bits_next;
            fmt_par   <= fmt_par_next;
            fmt_nstop <= fmt_nstop_next;
        end
    end

    // FIFO: a pop in the same cycle frees the slot, so push-at-full is legal then
    assign empty   = (level == '0);
    assign full    = (level == DEPTH_L);
    assign rxwm    = (level > {1'b0, watermark});
    assign rd_data = mem[rptr];
    assign do_pop  = rd_en && !empty;
    assign do_push = push_c && (!full || do_pop);
    assign ovr_set = push_c && full && !do_pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= shift_q;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop) rptr <= rptr + AW'(1);
            if (do_push && !do_pop)      level <= level + LW'(1);
            else if (do_pop && !do_push) level <= level - LW'(1);
        end
    end

    // Sticky flags: a new error wins over a simultaneous clear
    always_ff @(posedge clock) begin
        if (reset) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= perr_set | (parity_err & ~err_clr);
            frame_err  <= ferr_set | (frame_err & ~err_clr);
            overrun    <= ovr_set  | (overrun & ~err_clr);
        end
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised next-generation UART receive path for the peripheral bus.
- Provides 16x-oversampled serial reception, programmable frame format (5-8 data bits, none/even/odd parity, 1 or 2 stop bits) and a RX FIFO of configurable depth.
- Flags watermark, sticky error status and overrun.
- Sits behind the UART register front-end, which drives the configuration inputs and the pop strobe.

Parameters:
- FIFO_DEPTH, 8, number of RX FIFO entries; power of two, >= 2.
- AW, $clog2(FIFO_DEPTH), FIFO pointer width (derived; do not override).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset, sampled on rising edge of clock
- rx_en  in  1  receiver enable
- div  in  16  oversample divisor; one tick every div+1 clocks
- data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits
- parity_mode  in  2  00=none, 01=even, 10=odd, 11=none
- nstop  in  1  0=one stop bit, 1=two stop bits
- watermark  in  AW  RX watermark level
- err_clr  in  1  clears sticky error flags
- rxd  in  1  serial input, idle high, asynchronous
- rd_en  in  1  pop strobe, one entry per asserted cycle
- rd_data  out  8  FIFO head (first-word fall-through), zero-extended above data_bits
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- level  out  AW+1  number of stored entries
- rxwm  out  1  level > watermark
- parity_err  out  1  sticky parity error
- frame_err  out  1  sticky framing error
- overrun  out  1  sticky: frame dropped because FIFO full

Behaviour:
- Reset values:
  - FSM Idle, all counters and pointers 0, synchroniser flops 1.
  - level=0, empty=1, full=0, rxwm=0, rd_data=0.
  - All error flags 0.
- Synchroniser: rxd passes through 2 flops; the FSM uses only the synchronised value (rxs).
- Tick generator: counter counts 0..div; tick is a 1-clock pulse when count >= div, and the counter then returns to 0. div=0 gives a tick every clock. A new div takes effect at the next wrap.
- Bit timing: 16 ticks per bit; the sample counter (4 bits) samples at count 7 (mid-bit) and the bit ends at count 15.
- FSM states: Idle, Start, Data, Parity, Stop1, Stop2.
  - Idle: when rxs=0 and rx_en, clear the sample counter and go to Start. This check is evaluated every clock, not only on ticks.
  - Start: at mid-bit, rxs=1 means a false start: return to Idle, no push. Otherwise continue and go to Data at end of bit.
  - Data: shift rxs in LSB first at mid-bit. After data_bits+5 bits go to Parity if parity_mode is 01 or 10, else to Stop1.
  - Parity: at mid-bit, check even parity (XOR of data and parity bit = 0) or odd parity (XOR = 1). A mismatch sets parity_err.
  - Stop1: at mid-bit, rxs=0 sets frame_err. If nstop=1 go to Stop2 at end of bit. If nstop=0 push the frame and go to Idle at mid-bit.
  - Stop2: same check as Stop1; push and go to Idle at mid-bit.
- Frame format is latched at the Start to Data transition; config changes mid-frame do not affect the current frame.
- Errored frames (parity or framing) are still pushed.
- Push timing:
  - The push is registered; empty, level and rd_data update 1 clock after the final stop-bit sample tick.
  - Push while full (and no pop that cycle): the frame is dropped, overrun=1, FIFO unchanged.
- FIFO:
  - Pointers wrap modulo FIFO_DEPTH.
  - rd_en while empty is ignored.
  - Simultaneous push and pop: both occur and level is unchanged; this includes the full case, which is not an overrun.
- rxwm is combinational from level; full = (level == FIFO_DEPTH).
- Sticky error flags:
  - Each flag holds until err_clr is asserted.
  - If err_clr and a new error occur in the same cycle, set wins.
- rx_en=0:
  - FSM forced to Idle and any partial frame is discarded.
  - FIFO contents, pop and flags are retained.
- Reset mid-frame returns everything to reset values at the next clock edge.

Test Plan:
- Default depth, div=1 (32 clocks/bit), 8N1, send 0xA5 -> 1 clock after stop sample: empty=0, level=1, rd_data=0xA5, no error flags. Pulse rd_en -> empty=1.
- 7-bit even parity, 2 stop bits, send 0x35 with parity bit 0 -> rd_data=0x35, parity_err=0. Resend with parity bit 1 -> parity_err=1, byte 0x35 still stored, level=2.
- Glitch: rxd low for 4 ticks then high -> false start, FSM returns to Idle, level unchanged. A following valid 0x5A frame is received correctly.
- Stop bit driven 0 on 8N1 frame 0x0F -> frame_err=1, 0x0F stored. err_clr pulse -> frame_err=0.
- Send 9 frames 0x01..0x09 without popping -> full=1 and level=8 after the 8th, overrun=1, 0x09 dropped. 8 pops return 0x01..0x08 in order.
- Watermark and simultaneous push/pop:
  - watermark=3: level 3 gives rxwm=0; level 4 gives rxwm=1.
  - At full, pop in the same cycle as a push -> level stays 8, overrun stays 0, order preserved.
  - Assert reset mid-frame -> level=0, empty=1, all flags 0.
